// File: rtl/prienc8_debounce.sv
// Synchronise, debounce and priority-encode eight raw switch inputs.
// Define PRIENC_LATCH_EN to hold y at its last code when all stable bits clear.
module prienc8_debounce #(
    parameter  int DB_CYCLES = 4,
    localparam int CNT_W     = $clog2(DB_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    input  logic       en,
    output logic [2:0] y,
    output logic       valid,
    output logic       changed,
    output logic [7:0] stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [CNT_W-1:0] cnt [8];
    logic [2:0]       code;
    logic             v;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= x;
            sync2 <= sync1;
            // A bit must disagree with its stable value on DB_CYCLES
            // consecutive edges; any agreement restarts the count.
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        code = 3'd0;
        v    = |stable;
        for (int i = 0; i < 8; i++) begin
            if (stable[i]) begin
                code = 3'(i);
            end
        end
`ifdef PRIENC_LATCH_EN
        if (!v) begin
            code = y;
        end
`else
        if (!v) begin
            code = 3'd0;
        end
`endif
    end

    // The registered {valid,y} doubles as the previous-value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= 3'd0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else if (en) begin
            y       <= code;
            valid   <= v;
            changed <= ({v, code} != {valid, y});
        end else begin
            changed <= 1'b0;
        end
    end

endmodule
